// File: rtl/mcpu_mem_wordcli.sv
// Word-granular client adapter for one memory arbiter port.
// Turns 32-bit word requests into 256-bit line requests and returns
// the selected word of each read line, in request order.
module mcpu_mem_wordcli #(
    parameter int         MAX_OUT  = 4,
    parameter int         PTR_BITS = 2,
    parameter logic [2:0] OP_READ  = 3'b000,
    parameter logic [2:0] OP_WRITE = 3'b001
) (
    input  logic          clkrst_mem_clk,
    input  logic          clkrst_mem_rst,
    // word request side
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [29:0]   req_addr,
    input  logic [31:0]   req_wdata,
    input  logic [3:0]    req_be,
    output logic          resp_valid,
    output logic [31:0]   resp_rdata,
    // arbiter client side
    output logic          cli_valid,
    output logic [2:0]    cli_opcode,
    output logic [26:0]   cli_addr,
    output logic [255:0]  cli_wdata,
    output logic [31:0]   cli_wbe,
    input  logic          cli_stall,
    input  logic          cli_rvalid,
    input  logic [255:0]  cli_rdata,
    output logic          err_unexp_rvalid
);

    localparam int CNT_W = PTR_BITS + 1;

    logic [CNT_W-1:0]    cnt;
    logic [PTR_BITS-1:0] wr_ptr;
    logic [PTR_BITS-1:0] rd_ptr;
    logic [2:0]          sel_mem [MAX_OUT];

    logic slot_free;
    logic cnt_full;
    logic accept;
    logic push;
    logic pop;
    logic [2:0] head_sel;

    assign slot_free = ~cli_valid | ~cli_stall;
    assign cnt_full  = (cnt == CNT_W'(MAX_OUT));
    assign accept    = req_valid & req_ready;
    assign push      = accept & ~req_we;
    assign pop       = cli_rvalid & (cnt != '0);
    assign head_sel  = sel_mem[rd_ptr];

    // Ready: writes need only a free output slot, reads also need FIFO room.
    always_comb begin
        // NOTE: assign a default first so every path drives req_ready; otherwise a latch is inferred.
        req_ready = slot_free;
        if (!req_we && cnt_full) begin
            req_ready = 1'b0;
        end
    end

    // Arbiter request register: load on acceptance, hold while stalled, drop when drained.
    always_ff @(posedge clkrst_mem_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (clkrst_mem_rst) begin
            cli_valid  <= 1'b0;
            cli_opcode <= '0;
            cli_addr   <= '0;
            cli_wdata  <= '0;
            cli_wbe    <= '0;
        end else if (slot_free) begin
            if (accept) begin
                cli_valid  <= 1'b1;
                cli_opcode <= req_we ? OP_WRITE : OP_READ;
                cli_addr   <= req_addr[29:3];
                cli_wdata  <= {8{req_wdata}};
                cli_wbe    <= req_we ? ({28'b0, req_be} << {req_addr[2:0], 2'b00}) : 32'b0;
            end else begin
                cli_valid  <= 1'b0;
            end
        end
    end

    // Word-select FIFO storage: offset of each outstanding read.
    always_ff @(posedge clkrst_mem_clk) begin
        // NOTE: storage is not reset; pointers and cnt guard every read of it.
        if (push) begin
            sel_mem[wr_ptr] <= req_addr[2:0];
        end
    end

    // Read tracking: pointers, outstanding count and the sticky unexpected-return flag.
    always_ff @(posedge clkrst_mem_clk) begin
        if (clkrst_mem_rst) begin
            cnt              <= '0;
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            err_unexp_rvalid <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_BITS'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_BITS'(1);
            end
            if (push && !pop) begin
                cnt <= cnt + CNT_W'(1);
            end else if (pop && !push) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (cli_rvalid && cnt == '0) begin
                err_unexp_rvalid <= 1'b1;
            end
        end
    end

    // Response: select the recorded word one cycle after the line returns.
    always_ff @(posedge clkrst_mem_clk) begin
        if (clkrst_mem_rst) begin
            resp_valid <= 1'b0;
            resp_rdata <= '0;
        end else begin
            resp_valid <= pop;
            if (pop) begin
                resp_rdata <= cli_rdata[{head_sel, 5'b00000} +: 32];
            end
        end
    end

endmodule

// File: tb/tb_mcpu_mem_wordcli.sv
// Self-checking bench for mcpu_mem_wordcli: a table of per-cycle vectors
// plus a hand-written reset-with-reads-in-flight sequence.
module tb_mcpu_mem_wordcli;

    localparam logic [2:0] RD = 3'b000;
    localparam logic [2:0] WR = 3'b001;

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [29:0]   req_addr;
    logic [31:0]   req_wdata;
    logic [3:0]    req_be;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          cli_valid;
    logic [2:0]    cli_opcode;
    logic [26:0]   cli_addr;
    logic [255:0]  cli_wdata;
    logic [31:0]   cli_wbe;
    logic          cli_stall;
    logic          cli_rvalid;
    logic [255:0]  cli_rdata;
    logic          err_unexp_rvalid;

    int passed = 0;
    int total  = 0;

    mcpu_mem_wordcli dut (
        .clkrst_mem_clk   (clk),
        .clkrst_mem_rst   (rst),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_we           (req_we),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .req_be           (req_be),
        .resp_valid       (resp_valid),
        .resp_rdata       (resp_rdata),
        .cli_valid        (cli_valid),
        .cli_opcode       (cli_opcode),
        .cli_addr         (cli_addr),
        .cli_wdata        (cli_wdata),
        .cli_wbe          (cli_wbe),
        .cli_stall        (cli_stall),
        .cli_rvalid       (cli_rvalid),
        .cli_rdata        (cli_rdata),
        .err_unexp_rvalid (err_unexp_rvalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rv;
        logic        we;
        logic [29:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        stall;
        logic        rvv;
        logic [2:0]  rword;
        logic [31:0] rval;
        logic        e_ready;
        logic        e_cv;
        logic [2:0]  e_op;
        logic [26:0] e_caddr;
        logic [31:0] e_wbe;
        logic [31:0] e_wd;
        logic        e_rv;
        logic [31:0] e_rd;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Returned line: chosen word carries the value, every other word is a distinct marker.
    function automatic logic [255:0] line(input logic [2:0] w, input logic [31:0] val);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) begin
            l[32*i +: 32] = (i == int'(w)) ? val : (32'hBAD0_0000 | 32'(i));
        end
        return l;
    endfunction

    function automatic vec_t mk(
        input logic rv, input logic we, input logic [29:0] addr, input logic [3:0] be,
        input logic [31:0] wd, input logic stall, input logic rvv, input logic [2:0] rword,
        input logic [31:0] rval, input logic e_ready, input logic e_cv, input logic [2:0] e_op,
        input logic [26:0] e_caddr, input logic [31:0] e_wbe, input logic [31:0] e_wd,
        input logic e_rv, input logic [31:0] e_rd, input logic e_err);
        vec_t v;
        v.rv = rv; v.we = we; v.addr = addr; v.be = be; v.wd = wd; v.stall = stall;
        v.rvv = rvv; v.rword = rword; v.rval = rval; v.e_ready = e_ready; v.e_cv = e_cv;
        v.e_op = e_op; v.e_caddr = e_caddr; v.e_wbe = e_wbe; v.e_wd = e_wd;
        v.e_rv = e_rv; v.e_rd = e_rd; v.e_err = e_err;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        req_valid  = v.rv;
        req_we     = v.we;
        req_addr   = v.addr;
        req_be     = v.be;
        req_wdata  = v.wd;
        cli_stall  = v.stall;
        cli_rvalid = v.rvv;
        cli_rdata  = v.rvv ? line(v.rword, v.rval) : '0;
    endtask

    // One cycle: apply inputs, check ready before the edge, check registered outputs after it.
    task automatic step(input vec_t v, input int idx);
        drive(v);
        #1;
        check($sformatf("v%0d req_ready", idx), 256'(req_ready), 256'(v.e_ready));
        @(posedge clk);
        #1;
        check($sformatf("v%0d cli_valid", idx), 256'(cli_valid), 256'(v.e_cv));
        if (v.e_cv) begin
            check($sformatf("v%0d cli_opcode", idx), 256'(cli_opcode), 256'(v.e_op));
            check($sformatf("v%0d cli_addr", idx), 256'(cli_addr), 256'(v.e_caddr));
            check($sformatf("v%0d cli_wbe", idx), 256'(cli_wbe), 256'(v.e_wbe));
            check($sformatf("v%0d cli_wdata", idx), cli_wdata, {8{v.e_wd}});
        end
        check($sformatf("v%0d resp_valid", idx), 256'(resp_valid), 256'(v.e_rv));
        if (v.e_rv) begin
            check($sformatf("v%0d resp_rdata", idx), 256'(resp_rdata), 256'(v.e_rd));
        end
        check($sformatf("v%0d err_unexp", idx), 256'(err_unexp_rvalid), 256'(v.e_err));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " cli_valid"}, 256'(cli_valid), 256'(0));
        check({tag, " cli_opcode"}, 256'(cli_opcode), 256'(0));
        check({tag, " cli_addr"}, 256'(cli_addr), 256'(0));
        check({tag, " cli_wdata"}, cli_wdata, 256'(0));
        check({tag, " cli_wbe"}, 256'(cli_wbe), 256'(0));
        check({tag, " resp_valid"}, 256'(resp_valid), 256'(0));
        check({tag, " resp_rdata"}, 256'(resp_rdata), 256'(0));
        check({tag, " err_unexp"}, 256'(err_unexp_rvalid), 256'(0));
        check({tag, " req_ready"}, 256'(req_ready), 256'(1));
    endtask

    vec_t idle;

    initial begin
        idle = mk(0,0,0,0,0,0, 0,0,0, 1, 0,RD,0,0,0, 0,0,0);
        rst = 1'b1;
        drive(idle);
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst = 1'b0;

        // single read and its return
        vecs.push_back(mk(1,0,30'h15,0,0,0,            0,0,0,            1, 1,RD,27'h2,0,0,                  0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,                 1,5,32'hDEADBEEF, 1, 0,RD,0,0,0,                      1,32'hDEADBEEF,0));
        vecs.push_back(mk(0,0,0,0,0,0,                 0,0,0,            1, 0,RD,0,0,0,                      0,0,0));
        // write, then three stalled cycles, release on the fourth
        vecs.push_back(mk(1,1,30'h7,4'b0110,32'h11223344,0, 0,0,0,       1, 1,WR,27'h0,32'h6000_0000,32'h11223344, 0,0,0));
        for (int i = 0; i < 3; i++) begin
            vecs.push_back(mk(1,1,30'h8,4'hF,32'hAABBCCDD,1, 0,0,0,      0, 1,WR,27'h0,32'h6000_0000,32'h11223344, 0,0,0));
        end
        vecs.push_back(mk(1,1,30'h8,4'hF,32'hAABBCCDD,0, 0,0,0,          1, 1,WR,27'h1,32'h0000_000F,32'hAABBCCDD, 0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,                 0,0,0,            1, 0,RD,0,0,0,                      0,0,0));
        // four back-to-back reads to offsets 0,3,7,1
        vecs.push_back(mk(1,0,30'h20,0,0,0,            0,0,0,            1, 1,RD,27'h4,0,0,                  0,0,0));
        vecs.push_back(mk(1,0,30'h23,0,0,0,            0,0,0,            1, 1,RD,27'h4,0,0,                  0,0,0));
        vecs.push_back(mk(1,0,30'h27,0,0,0,            0,0,0,            1, 1,RD,27'h4,0,0,                  0,0,0));
        vecs.push_back(mk(1,0,30'h29,0,0,0,            0,0,0,            1, 1,RD,27'h5,0,0,                  0,0,0));
        // fifth read refused, write still accepted
        vecs.push_back(mk(1,0,30'h30,0,0,0,            0,0,0,            0, 0,RD,0,0,0,                      0,0,0));
        vecs.push_back(mk(1,1,30'h31,4'b0001,32'h55667788,0, 0,0,0,      1, 1,WR,27'h6,32'h0000_0010,32'h55667788, 0,0,0));
        // full with return and read in the same cycle: refused now, accepted next
        vecs.push_back(mk(1,0,30'h2A,0,0,0,            1,0,32'hA0A0A0A0, 0, 0,RD,0,0,0,                      1,32'hA0A0A0A0,0));
        vecs.push_back(mk(1,0,30'h2A,0,0,0,            0,0,0,            1, 1,RD,27'h5,0,0,                  0,0,0));
        vecs.push_back(mk(1,0,30'h2B,0,0,0,            0,0,0,            0, 0,RD,0,0,0,                      0,0,0));
        // drain in order: offsets 3,7,1,2
        vecs.push_back(mk(0,0,0,0,0,0,                 1,3,32'h33333333, 0, 0,RD,0,0,0,                      1,32'h33333333,0));
        vecs.push_back(mk(0,0,0,0,0,0,                 1,7,32'h77777777, 1, 0,RD,0,0,0,                      1,32'h77777777,0));
        vecs.push_back(mk(0,0,0,0,0,0,                 1,1,32'h11111111, 1, 0,RD,0,0,0,                      1,32'h11111111,0));
        vecs.push_back(mk(0,0,0,0,0,0,                 1,2,32'h22222222, 1, 0,RD,0,0,0,                      1,32'h22222222,0));
        vecs.push_back(mk(0,0,0,0,0,0,                 0,0,0,            1, 0,RD,0,0,0,                      0,0,0));
        // unexpected return: sticky error, no response
        vecs.push_back(mk(0,0,0,0,0,0,                 1,0,32'hFFFFFFFF, 1, 0,RD,0,0,0,                      0,0,1));
        vecs.push_back(mk(0,0,0,0,0,0,                 0,0,0,            1, 0,RD,0,0,0,                      0,0,1));

        foreach (vecs[i]) begin
            step(vecs[i], i);
        end

        // reset with two reads outstanding and a request on the arbiter port
        step(mk(1,0,30'h40,0,0,0, 0,0,0, 1, 1,RD,27'h8,0,0, 0,0,1), 100);
        step(mk(1,0,30'h48,0,0,0, 0,0,0, 1, 1,RD,27'h9,0,0, 0,0,1), 101);
        drive(idle);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_state("rst_inflight");
        rst = 1'b0;
        // return for the abandoned read is unexpected
        drive(mk(0,0,0,0,0,0, 1,0,32'hCAFEF00D, 1, 0,RD,0,0,0, 0,0,0));
        @(posedge clk);
        #1;
        check("abandoned resp_valid", 256'(resp_valid), 256'(0));
        check("abandoned err_unexp", 256'(err_unexp_rvalid), 256'(1));
        drive(idle);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
